alu_sout_decoder: RTL and testbench

ALU_SOUT_DECODER -- requirements
Module: alu_sout_decoder

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_sout_pkt_rx.sv | 58 +++++
 rtl/alu_sout_decoder.sv | 129 ++++++++++++
 tb/tb_alu_sout_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, decoder state encoding and the CRC3 helper for the ALU sout decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  // One packet on the line: start, type, 8 payload bits, stop
  localparam int PKT_LEN = 11;

  // Type bit encodings
  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CTRL = 1'b1;

  // Packet receiver states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EVAL  = 2'd2
  } dec_state_t;

  // Bit positions inside result_flags
  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  // x^3 + x + 1, leading term implicit
  localparam logic [2:0] CRC3_POLY = 3'b011;

  // Serial CRC3 over {C, 1'b0, FLAGS}, MSB first, init 0
  function automatic logic [2:0] crc3_calc(input logic [31:0] c, input logic [3:0] flags);
    logic [36:0] msg;
    logic [2:0]  crc;
    logic        fb;
    msg = {c, 1'b0, flags};
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_sout_pkt_rx.sv
// Packet deserializer: start detect, 10-bit capture (type, payload, stop), one EVAL cycle.
// Latency: pkt_done is asserted combinationally in the cycle the stop bit is on the line.
// Backpressure: none; the serial line cannot be stalled, a start bit seen in EVAL is ignored.
module alu_sout_pkt_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
  output logic       rx_gap,
  output logic       pkt_done,
  output logic [9:0] pkt_bits
);
  import alu_pkg::*;

  // Index of the stop bit within the 10 captured bits
  localparam logic [3:0] LAST_IDX = 4'(PKT_LEN - 2);

  dec_state_t state;
  logic [3:0] bit_cnt;
  logic [8:0] shreg;

  // Receiver FSM: wait for start, shift 10 bits, spend one cycle in EVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 9'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!sout) begin
            state   <= ST_SHIFT;
            bit_cnt <= 4'd0;
          end
        end
        ST_SHIFT: begin
          shreg <= {shreg[7:0], sout};
          if (bit_cnt == LAST_IDX) begin
            state   <= ST_EVAL;
            bit_cnt <= 4'd0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_EVAL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The stop bit is taken straight from the line so the decoder can register its
  // result on the same edge that samples the stop bit; outputs then show in EVAL.
  assign pkt_done = (state == ST_SHIFT) && (bit_cnt == LAST_IDX);
  assign pkt_bits = {shreg, sout};

  // Inter-packet gap: anything that is not mid-packet
  assign rx_gap = (state != ST_SHIFT);

endmodule

// File: rtl/alu_sout_decoder.sv
// ALU sout response decoder: 4 data bytes + control packet -> result, or control-only -> error.
// Latency: outputs and pulses appear in the cycle after the stop bit is on the line (EVAL).
// Backpressure: none; optional CRC3 checker built when ALU_DEC_CRC_CHECK_EN is defined.
module alu_sout_decoder #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        result_valid,
  output logic [31:0] result_c,
  output logic [3:0]  result_flags,
  output logic        crc_ok,
  output logic        err_valid,
  output logic [5:0]  err_flags,
  output logic        parity_ok,
  output logic        frame_err
);
  import alu_pkg::*;

  localparam int              ICW        = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [ICW-1:0]  IDLE_LIMIT = ICW'(IDLE_TIMEOUT);

  logic           rx_gap;
  logic           pkt_done;
  logic [9:0]     pkt_bits;
  logic           pkt_type;
  logic [7:0]     pkt_payload;
  logic           pkt_stop;
  logic [2:0]     data_cnt;
  logic [ICW-1:0] idle_cnt;
  logic [31:0]    c_acc;
  logic           timeout_hit;
  logic           crc_match;

  alu_sout_pkt_rx u_pkt_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .sout     (sout),
    .rx_gap   (rx_gap),
    .pkt_done (pkt_done),
    .pkt_bits (pkt_bits)
  );

  assign pkt_type    = pkt_bits[9];
  assign pkt_payload = pkt_bits[8:1];
  assign pkt_stop    = pkt_bits[0];

`ifdef ALU_DEC_CRC_CHECK_EN
  assign crc_match = (crc3_calc(c_acc, pkt_payload[6:3]) == pkt_payload[2:0]);
`else
  // Without the checker the received CRC field is ignored
  logic unused_crc_bits;
  assign unused_crc_bits = ^pkt_payload[2:0];
  assign crc_match       = 1'b1;
`endif

  // Expiry is checked before the start-bit test so a start bit in the expiry
  // cycle still begins a packet after the frame error.
  assign timeout_hit = rx_gap && (data_cnt != 3'd0) && (idle_cnt == IDLE_LIMIT);

  // Count consecutive high gap cycles while a response is partially received
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!rx_gap || (data_cnt == 3'd0) || timeout_hit || !sout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Response assembly and decode; pulses last exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_cnt     <= 3'd0;
      c_acc        <= 32'd0;
      result_valid <= 1'b0;
      err_valid    <= 1'b0;
      frame_err    <= 1'b0;
      result_c     <= 32'd0;
      result_flags <= 4'd0;
      crc_ok       <= 1'b0;
      err_flags    <= 6'd0;
      parity_ok    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err_valid    <= 1'b0;
      frame_err    <= 1'b0;
      if (timeout_hit) begin
        frame_err <= 1'b1;
        data_cnt  <= 3'd0;
      end else if (pkt_done) begin
        if (!pkt_stop) begin
          frame_err <= 1'b1;
          data_cnt  <= 3'd0;
        end else if (pkt_type == TYPE_DATA) begin
          if (data_cnt == 3'd4) begin
            frame_err <= 1'b1;
            data_cnt  <= 3'd0;
          end else begin
            c_acc    <= {c_acc[23:0], pkt_payload};
            data_cnt <= data_cnt + 3'd1;
          end
        end else if (!pkt_payload[7]) begin
          if (data_cnt == 3'd4) begin
            result_valid <= 1'b1;
            result_c     <= c_acc;
            result_flags <= pkt_payload[6:3];
            crc_ok       <= crc_match;
          end else begin
            frame_err <= 1'b1;
          end
          data_cnt <= 3'd0;
        end else begin
          if (data_cnt == 3'd0) begin
            err_valid <= 1'b1;
            err_flags <= pkt_payload[6:1];
            parity_ok <= ~^pkt_payload;
          end else begin
            frame_err <= 1'b1;
          end
          data_cnt <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sout_decoder.sv
// Self-checking bench for alu_sout_decoder: table of responses plus corner sequences.
// Latency: expected pulses are scheduled one cycle after the stop bit (or at timeout expiry).
// Backpressure: none; the bench drives the serial line freely.
module tb_alu_sout_decoder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sout = 1'b1;
  logic        result_valid;
  logic [31:0] result_c;
  logic [3:0]  result_flags;
  logic        crc_ok;
  logic        err_valid;
  logic [5:0]  err_flags;
  logic        parity_ok;
  logic        frame_err;

  alu_sout_decoder #(.IDLE_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sout         (sout),
    .result_valid (result_valid),
    .result_c     (result_c),
    .result_flags (result_flags),
    .crc_ok       (crc_ok),
    .err_valid    (err_valid),
    .err_flags    (err_flags),
    .parity_ok    (parity_ok),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // kind: 0 result, 1 error response, 2 frame error
  typedef struct {
    int          kind;
    int          when;
    logic [31:0] c;
    logic [3:0]  f;
    logic        crc;
    logic [5:0]  ef;
    logic        par;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic        is_err;
    logic [31:0] c;
    logic [3:0]  f;
    logic        flip;
    logic [7:0]  epl;
    logic        exp_crc_ok;
    logic [5:0]  exp_ef;
    logic        exp_par;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference CRC by polynomial long division of {C,0,FLAGS,000} by 1011
  function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  task automatic push(input int kind, input int when, input logic [31:0] c, input logic [3:0] f,
                      input logic crc, input logic [5:0] ef, input logic par);
    exp_t x;
    x.kind = kind; x.when = when; x.c = c; x.f = f; x.crc = crc; x.ef = ef; x.par = par;
    sb.push_back(x);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    sout = b;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stp,
                          input int gap, output int stop_cyc);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(typ);
    for (int i = 7; i >= 0; i--) drive_bit(pl[i]);
    drive_bit(stp);
    stop_cyc = cyc;
  endtask

  task automatic send_data_resp(input logic [31:0] c, input logic [3:0] f, input logic flip,
                                input logic exp_crc, input int first_gap);
    int sc;
    logic [2:0] crc;
    for (int b = 3; b >= 0; b--) send_pkt(1'b0, c[8*b +: 8], 1'b1, (b == 3) ? first_gap : 2, sc);
    crc = crc_model(c, f) ^ {2'b00, flip};
    send_pkt(1'b1, {1'b0, f, crc}, 1'b1, 2, sc);
    push(0, sc + 1, c, f, exp_crc, 6'd0, 1'b0);
  endtask

  task automatic send_err_resp(input logic [7:0] pl, input logic [5:0] ef, input logic par);
    int sc;
    send_pkt(1'b1, pl, 1'b1, 2, sc);
    push(1, sc + 1, 32'd0, 4'd0, 1'b0, ef, par);
  endtask

  // Scoreboard: every pulse must match the oldest pending expectation
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0 && sb[0].when < cyc) begin
      chk("pulse_missing_at_cycle", cyc, sb[0].when);
      void'(sb.pop_front());
    end
    if (result_valid || err_valid || frame_err) begin
      chk("pulse_exclusive", $countones({result_valid, err_valid, frame_err}), 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, result_valid, err_valid, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", result_valid ? 0 : (err_valid ? 1 : 2), e.kind);
        chk("pulse_cycle", cyc, e.when);
        if (e.kind == 0) begin
          chk("result_c", result_c, e.c);
          chk("result_flags", {28'd0, result_flags}, {28'd0, e.f});
          chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.crc});
        end else if (e.kind == 1) begin
          chk("err_flags", {26'd0, err_flags}, {26'd0, e.ef});
          chk("parity_ok", {31'd0, parity_ok}, {31'd0, e.par});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_err_valid"}, {31'd0, err_valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_result_c"}, result_c, 32'd0);
    chk({tag, "_result_flags"}, {28'd0, result_flags}, 32'd0);
    chk({tag, "_err_flags"}, {26'd0, err_flags}, 32'd0);
    chk({tag, "_crc_ok"}, {31'd0, crc_ok}, 32'd0);
    chk({tag, "_parity_ok"}, {31'd0, parity_ok}, 32'd0);
  endtask

  logic crc_bad_exp;
  int   sc;

  initial begin
`ifdef ALU_DEC_CRC_CHECK_EN
    crc_bad_exp = 1'b0;
`else
    crc_bad_exp = 1'b1;
`endif
    //           is_err c             f      flip  epl    crc_ok       ef         par
    vt[0] = '{1'b0, 32'h00000003, 4'h0, 1'b0, 8'h00, 1'b1,        6'd0,      1'b0};
    vt[1] = '{1'b0, 32'h00000003, 4'h0, 1'b1, 8'h00, crc_bad_exp, 6'd0,      1'b0};
    vt[2] = '{1'b0, 32'hDEADBEEF, 4'hA, 1'b0, 8'h00, 1'b1,        6'd0,      1'b0};
    vt[3] = '{1'b0, 32'hFFFFFFFF, 4'hF, 1'b0, 8'h00, 1'b1,        6'd0,      1'b0};
    vt[4] = '{1'b0, 32'h00000000, 4'h4, 1'b0, 8'h00, 1'b1,        6'd0,      1'b0};
    vt[5] = '{1'b1, 32'h0,        4'h0, 1'b0, 8'h93, 1'b0,        6'b001001, 1'b1};
    vt[6] = '{1'b1, 32'h0,        4'h0, 1'b0, 8'h92, 1'b0,        6'b001001, 1'b0};
    vt[7] = '{1'b1, 32'h0,        4'h0, 1'b0, 8'hFF, 1'b0,        6'b111111, 1'b1};
    vt[8] = '{1'b1, 32'h0,        4'h0, 1'b0, 8'h80, 1'b0,        6'b000000, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table of complete responses
    for (int i = 0; i < 9; i++) begin
      if (vt[i].is_err) send_err_resp(vt[i].epl, vt[i].exp_ef, vt[i].exp_par);
      else send_data_resp(vt[i].c, vt[i].f, vt[i].flip, vt[i].exp_crc_ok, 2);
    end

    // Idle timeout after two data bytes, line high for 65 cycles, then a clean response
    send_pkt(1'b0, 8'h11, 1'b1, 2, sc);
    send_pkt(1'b0, 8'h22, 1'b1, 2, sc);
    push(2, sc + TO + 2, 32'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    send_data_resp(32'h12345678, 4'h5, 1'b0, 1'b1, 65);

    // Start bit exactly at timeout expiry is accepted as the first byte of a new response
    send_pkt(1'b0, 8'h33, 1'b1, 2, sc);
    push(2, sc + TO + 2, 32'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    send_data_resp(32'hA5A5_0F0F, 4'h3, 1'b0, 1'b1, TO);

    // Stop bit 0 on the third data packet
    send_pkt(1'b0, 8'h01, 1'b1, 2, sc);
    send_pkt(1'b0, 8'h02, 1'b1, 2, sc);
    send_pkt(1'b0, 8'h03, 1'b0, 2, sc);
    push(2, sc + 1, 32'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    send_data_resp(32'h0BADF00D, 4'h8, 1'b0, 1'b1, 2);

    // Fifth data packet, then an error response must still be accepted
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'(i + 1), 1'b1, 2, sc);
    push(2, sc + 1, 32'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    send_err_resp(8'h93, 6'b001001, 1'b1);

    // Data-type control after only two data bytes
    send_pkt(1'b0, 8'h44, 1'b1, 2, sc);
    send_pkt(1'b0, 8'h55, 1'b1, 2, sc);
    send_pkt(1'b1, 8'h06, 1'b1, 2, sc);
    push(2, sc + 1, 32'd0, 4'd0, 1'b0, 6'd0, 1'b0);

    // Error control after one data byte, then a clean response
    send_pkt(1'b0, 8'h66, 1'b1, 2, sc);
    send_pkt(1'b1, 8'h93, 1'b1, 2, sc);
    push(2, sc + 1, 32'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    send_data_resp(32'hCAFEF00D, 4'h9, 1'b0, 1'b1, 2);

    // Reset mid-packet inside a partial response
    send_pkt(1'b0, 8'h77, 1'b1, 2, sc);
    send_pkt(1'b0, 8'h88, 1'b1, 2, sc);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    sout  = 1'b1;
    rst_n = 1'b1;
    send_data_resp(32'h00000003, 4'h0, 1'b0, 1'b1, 2);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
